mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
// - Shares the single external memory port between the I-cache and D-cache controllers.
// - Each requester issues whole-block bursts: line refill (read) or dirty write-back (write).
// - A grant is locked for the full burst. Arbitration between bursts is round-robin.
// - The arbiter generates the per-word offset, so each cache controller only streams data.
// PARAMETERS
// - OFFSET_WIDTH  `CACHE_B  byte-offset bits per block; BLOCK_WORDS = 2**(OFFSET_WIDTH-2)
// - ADDR_WIDTH    32        byte address width
// - DATA_WIDTH    32        word width
// PORTS
// - clk         in   1            clock; all state updates on the rising edge
// - reset       in   1            asynchronous, active-low (0 = reset)
// - i_req       in   1            I-side burst request; held high until its last beat
// - i_we        in   1            I-side direction, 1 = write; tied 0 by the I-cache
// - i_addr      in   ADDR_WIDTH   I-side block base address (offset bits ignored)
// - i_wdata     in   DATA_WIDTH   I-side write word for the current offset
// - i_ready     out  1            I-side beat accepted / rdata valid this cycle
// - i_offset    out  OFFSET_WIDTH-2  word index of the current I-side beat
// - d_req, d_we, d_addr, d_wdata, d_ready, d_offset: same as above for the D-cache
// - rdata       out  DATA_WIDTH   m_rdata forwarded to both requesters; qualify with x_ready
// - m_en        out  1            memory access valid
// - m_we        out  1            memory write
// - m_addr      out  ADDR_WIDTH   {base[ADDR_WIDTH-1:OFFSET_WIDTH], count, 2'b00}
// - m_wdata     out  DATA_WIDTH   write word from the granted requester
// - m_ready     in   1            memory completes the current beat this cycle
// BEHAVIOUR
// - Reset values:
//   - state = IDLE, count = 0, last = D (so I wins the first tie).
//   - All outputs 0: m_en, m_we, m_addr, m_wdata, i/d_ready, i/d_offset, rdata.
// - States: IDLE, BURST_I, BURST_D.
//   - IDLE, one req: grant it.
//   - IDLE, both req: grant the one that is not `last`.
//   - IDLE, no req: stay in IDLE.
//   - The transition takes effect next cycle, so grant latency is 1 cycle from req.
//   - count is cleared on grant.
// - BURST_x:
//   - m_en = 1; m_we = x_we; m_addr built from x_addr and count.
//   - m_wdata = x_wdata; x_offset = count.
//   - x_ready = m_ready, combinational, gated by state. The non-granted ready is always 0.
//   - On m_ready: count++.
//   - If count == BLOCK_WORDS-1 on that beat: return to IDLE, last <= x, count <= 0.
// - Burst length is BLOCK_WORDS beats. A write-back followed by a refill is two separate
//   bursts; the other requester may win in between (round-robin).
// - m_ready with m_en=0 (IDLE) is ignored. Memory may stall indefinitely; nothing times out.
// - Requester drops x_req mid-burst: abort. IDLE next cycle, count <= 0, last unchanged.
//   - A beat completing in that same cycle is still delivered (x_ready=1) but not counted.
// - New req in the same cycle as the last beat: it cannot be granted until the following
//   cycle. There is exactly one IDLE cycle between bursts.
// - x_we or x_addr changing mid-burst is illegal. Sample and assert stability in the bench.
// - Offset bits of x_addr are ignored. m_addr[1:0] is always 00.
// - reset low mid-burst: immediate return to reset values. m_en drops asynchronously.
// STRUCTURE
// - Shared package cache_pkg:
//   - typedef enum logic [1:0] {ARB_IDLE, ARB_BURST_I, ARB_BURST_D} arb_state_t
//   - requester id localparams REQ_I = 1'b0, REQ_D = 1'b1
//   - BLOCK_WORDS derived from `CACHE_B
// - Sub-module rr_pick2: two-input round-robin selector.
//   - Inputs: req[1:0], last. Outputs: valid, winner.
//   - Purely combinational; last is held in the parent.
// - Parent holds the state register, the beat counter, and the output muxes.
// TESTING
// - Reset, then d_req=1 (read, d_addr=0x1000_0004), m_ready every cycle:
//   - grant after 1 cycle; m_addr sequence 0x1000_0000/04/08/0C
//   - d_ready 4 cycles, d_offset 0..3, then IDLE.
// - i_req and d_req asserted together straight from reset:
//   - I burst first (last = D at reset), then D after one IDLE cycle.
//   - Repeat both: order alternates I, D, I, D.
// - D write-back (d_we=1), m_ready stalled 3 cycles per beat:
//   - m_en and m_addr held stable while stalled; exactly 4 writes.
//   - i_ready stays 0 throughout, even with i_req=1.
// - d_req dropped after 2 beats:
//   - IDLE next cycle; count 0; pending i_req granted.
//   - A subsequent d_req restarts at offset 0.
// - reset asserted during beat 2 of an I burst:
//   - m_en=0 immediately; state IDLE, count 0.
//   - After release, the same i_req restarts at offset 0.
// - m_ready=1 while IDLE and no req: no ready pulses, count stays 0.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared definitions for the cache memory-port logic.
//   arb_state_t  : state of the memory port arbiter
//   REQ_I/REQ_D  : requester ids, also used as the round-robin "last" value
//   BLOCK_WORDS  : words per cache block, derived from `CACHE_B
`ifndef CACHE_B
`define CACHE_B 4
`endif

package cache_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_BURST_I = 2'd1,
        ARB_BURST_D = 2'd2
    } arb_state_t;

    localparam logic REQ_I = 1'b0;
    localparam logic REQ_D = 1'b1;

    // `CACHE_B counts byte-offset bits; two of them select the byte within a word.
    localparam int BLOCK_WORDS = 2 ** (`CACHE_B - 2);

endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Two-input round-robin selector.
//   req[1:0] : in  request vector, index REQ_I / REQ_D
//   last     : in  id of the requester that finished the previous burst
//   valid    : out at least one request present
//   winner   : out chosen requester id (meaningful only when valid)
// Purely combinational; the parent keeps `last` in a register.
module rr_pick2
    import cache_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       valid,
    output logic       winner
);

    always_comb begin
        valid  = |req;
        winner = REQ_I;
        if (req == 2'b11) begin
            // Tie: the requester that was not served last goes next.
            winner = ~last;
        end else if (req[REQ_D]) begin
            winner = REQ_D;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Memory port arbiter: shares one external memory port between the I-cache
// and D-cache controllers. Each grant is locked for a whole-block burst of
// BLOCK_WORDS beats; arbitration between bursts is round-robin. The arbiter
// generates the word offset so the cache controllers only stream data.
//
// Ports
//   clk, reset           : clock; asynchronous active-low reset
//   i_req/i_we/i_addr/i_wdata : I-side burst request, direction, block base, write word
//   i_ready, i_offset    : I-side beat accepted this cycle, word index of current beat
//   d_*                  : same set for the D-cache
//   rdata                : m_rdata forwarded to both sides, qualified by x_ready
//   m_en/m_we/m_addr/m_wdata : memory access request
//   m_ready, m_rdata     : memory completes the current beat / read data
//   dbg_state, dbg_count : current arbiter state and beat counter
//
// Handshake: a beat transfers in the cycle where m_en && m_ready. In that
// same cycle the granted side sees x_ready = 1 (its write word was taken or
// rdata is valid) and advances its data for the next offset. A requester
// holds x_req, x_we and x_addr steady until its last beat; dropping x_req
// early aborts the burst.
module mem_port_arbiter
    import cache_pkg::*;
#(
    parameter int OFFSET_WIDTH = `CACHE_B,
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32
) (
    input  logic                    clk,
    input  logic                    reset,

    input  logic                    i_req,
    input  logic                    i_we,
    input  logic [ADDR_WIDTH-1:0]   i_addr,
    input  logic [DATA_WIDTH-1:0]   i_wdata,
    output logic                    i_ready,
    output logic [OFFSET_WIDTH-3:0] i_offset,

    input  logic                    d_req,
    input  logic                    d_we,
    input  logic [ADDR_WIDTH-1:0]   d_addr,
    input  logic [DATA_WIDTH-1:0]   d_wdata,
    output logic                    d_ready,
    output logic [OFFSET_WIDTH-3:0] d_offset,

    output logic [DATA_WIDTH-1:0]   rdata,

    output logic                    m_en,
    output logic                    m_we,
    output logic [ADDR_WIDTH-1:0]   m_addr,
    output logic [DATA_WIDTH-1:0]   m_wdata,
    input  logic                    m_ready,
    input  logic [DATA_WIDTH-1:0]   m_rdata,

    output arb_state_t              dbg_state,
    output logic [OFFSET_WIDTH-3:0] dbg_count
);

    localparam int CW = OFFSET_WIDTH - 2;
    localparam logic [CW-1:0] LAST_BEAT = {CW{1'b1}};

    arb_state_t    state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic          last_q, last_d;

    logic          pick_valid;
    logic          pick_winner;

    // Fields of whichever requester currently owns the port.
    logic                  busy;
    logic                  gnt;
    logic                  sel_req;
    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;

    // Offset bits of the requester addresses are replaced by the counter.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{i_addr[OFFSET_WIDTH-1:0], d_addr[OFFSET_WIDTH-1:0]};

    rr_pick2 u_pick (
        .req    ({d_req, i_req}),
        .last   (last_q),
        .valid  (pick_valid),
        .winner (pick_winner)
    );

    assign busy      = (state_q == ARB_BURST_I) || (state_q == ARB_BURST_D);
    assign gnt       = (state_q == ARB_BURST_D) ? REQ_D : REQ_I;
    assign sel_req   = (gnt == REQ_D) ? d_req   : i_req;
    assign sel_we    = (gnt == REQ_D) ? d_we    : i_we;
    assign sel_addr  = (gnt == REQ_D) ? d_addr  : i_addr;
    assign sel_wdata = (gnt == REQ_D) ? d_wdata : i_wdata;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ARB_IDLE;
            count_q <= '0;
            last_q  <= REQ_D;   // so I wins the first tie
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        last_d  = last_q;

        if (!busy) begin
            // Covers ARB_IDLE and the unused encoding, which recovers to idle.
            state_d = ARB_IDLE;
            count_d = '0;
            if (pick_valid) begin
                state_d = (pick_winner == REQ_D) ? ARB_BURST_D : ARB_BURST_I;
            end
        end else if (!sel_req) begin
            // Abort: a beat completing this cycle is still delivered but not
            // counted, and the round-robin history is left alone.
            state_d = ARB_IDLE;
            count_d = '0;
        end else if (m_ready) begin
            if (count_q == LAST_BEAT) begin
                state_d = ARB_IDLE;
                count_d = '0;
                last_d  = gnt;
            end else begin
                count_d = count_q + CW'(1);
            end
        end
    end

    always_comb begin
        m_en     = 1'b0;
        m_we     = 1'b0;
        m_addr   = '0;
        m_wdata  = '0;
        rdata    = '0;
        i_ready  = 1'b0;
        d_ready  = 1'b0;
        i_offset = '0;
        d_offset = '0;

        if (busy) begin
            m_en    = 1'b1;
            m_we    = sel_we;
            m_addr  = {sel_addr[ADDR_WIDTH-1:OFFSET_WIDTH], count_q, 2'b00};
            m_wdata = sel_wdata;
            rdata   = m_rdata;
            if (gnt == REQ_D) begin
                d_ready  = m_ready;
                d_offset = count_q;
            end else begin
                i_ready  = m_ready;
                i_offset = count_q;
            end
        end
    end

    assign dbg_state = state_q;
    assign dbg_count = count_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
module tb_mem_port_arbiter;
  import cache_pkg::*;

  localparam int OW = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int EW = 68;  // beat record {id, we, offset[1:0], addr, wdata}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic          i_req, i_we, d_req, d_we, m_ready;
  logic [AW-1:0] i_addr, d_addr, m_addr;
  logic [DW-1:0] i_wdata, d_wdata, m_rdata, m_wdata, rdata;
  logic          i_ready, d_ready, m_en, m_we;
  logic [OW-3:0] i_offset, d_offset, dbg_count;
  arb_state_t    dbg_state;

  mem_port_arbiter #(.OFFSET_WIDTH(OW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_we(i_we), .i_addr(i_addr), .i_wdata(i_wdata),
    .i_ready(i_ready), .i_offset(i_offset),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_offset(d_offset),
    .rdata(rdata),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ready(m_ready), .m_rdata(m_rdata),
    .dbg_state(dbg_state), .dbg_count(dbg_count)
  );

  // Requester inputs must not move while their burst owns the port.
  a_i_stable: assert property (@(posedge clk) disable iff (!reset)
    (dbg_state == ARB_BURST_I && $past(dbg_state) == ARB_BURST_I) |-> ($stable(i_addr) && $stable(i_we)));
  a_d_stable: assert property (@(posedge clk) disable iff (!reset)
    (dbg_state == ARB_BURST_D && $past(dbg_state) == ARB_BURST_D) |-> ($stable(d_addr) && $stable(d_we)));

  // ---------------- bench state ----------------
  int errors = 0;
  int checks = 0;

  bit            i_act, d_act;
  int            i_beat, d_beat, i_stop, d_stop;
  logic [DW-1:0] i_base, d_base;
  int            stall, wait_cnt;
  bit            rnd_mem;

  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] obs_q[$];
  int            gaps[$];
  int            first_en, bad_ready, unstable, rd_diff;
  bit            timed_out;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    i_req = 0; d_req = 0; i_act = 0; d_act = 0; i_we = 0; d_we = 0;
    i_addr = '0; d_addr = '0; i_wdata = '0; d_wdata = '0;
    m_ready = 0; m_rdata = '0;
    reset = 0;
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1;
    @(posedge clk); #1;
  endtask

  task automatic clear_obs();
    exp_q.delete(); obs_q.delete(); gaps.delete();
    bad_ready = 0; unstable = 0; rd_diff = 0;
  endtask

  task automatic set_mem(input int s, input bit r);
    stall = s; rnd_mem = r; wait_cnt = 0;
    m_ready = r ? 1'($urandom_range(0, 1)) : (s == 0);
    m_rdata = $urandom;
  endtask

  task automatic start_req(input bit id, input bit we, input logic [AW-1:0] addr, input int stop);
    if (id == REQ_I) begin
      i_act = 1; i_beat = 0; i_stop = stop; i_base = $urandom;
      i_we = we; i_addr = addr; i_wdata = i_base; i_req = 1;
    end else begin
      d_act = 1; d_beat = 0; d_stop = stop; d_base = $urandom;
      d_we = we; d_addr = addr; d_wdata = d_base; d_req = 1;
    end
  endtask

  // Reference: a burst is nbeats consecutive words of the aligned block.
  task automatic expect_burst(input bit id, input bit we, input logic [AW-1:0] addr,
                              input logic [DW-1:0] base, input int nbeats);
    logic [AW-1:0] blk;
    blk = {addr[AW-1:OW], {OW{1'b0}}};
    for (int k = 0; k < nbeats; k++)
      exp_q.push_back({id, we, 2'(k), blk + AW'(4 * k), base + DW'(k)});
  endtask

  // Runs cycles while any requester is active, recording what the port does.
  task automatic run(input int max_cycles);
    int n, gap;
    bit prev_en, seen_en, hold_valid, s_i, s_d, s_en, s_rdy, hold_we;
    logic [AW-1:0] hold_addr;
    n = 0; gap = 0; prev_en = 0; seen_en = 0; hold_valid = 0; hold_we = 0; hold_addr = '0;
    gaps.delete(); first_en = -1; timed_out = 0;
    while ((i_act || d_act) && n < max_cycles) begin
      @(negedge clk);
      if (m_en) begin
        if (seen_en && !prev_en) gaps.push_back(gap);
        if (!seen_en) first_en = n;
        seen_en = 1; gap = 0;
      end else if (seen_en) begin
        gap++;
      end
      prev_en = m_en;
      if (i_ready && d_ready) bad_ready++;
      if ((i_ready || d_ready) && !(m_en && m_ready)) bad_ready++;
      if (hold_valid && m_en && (m_addr !== hold_addr || m_we !== hold_we)) unstable++;
      hold_valid = m_en && !m_ready; hold_addr = m_addr; hold_we = m_we;
      if (m_en && m_ready) begin
        obs_q.push_back({d_ready, m_we, (d_ready ? d_offset : i_offset), m_addr, m_wdata});
        if (rdata !== m_rdata) rd_diff++;
      end
      s_i = i_ready; s_d = d_ready; s_en = m_en; s_rdy = m_ready;
      @(posedge clk); #1;
      if (i_act && s_i) begin
        i_beat++;
        if (i_beat == i_stop) begin i_act = 0; i_req = 0; end
      end
      if (d_act && s_d) begin
        d_beat++;
        if (d_beat == d_stop) begin d_act = 0; d_req = 0; end
      end
      i_wdata = i_base + DW'(i_beat);
      d_wdata = d_base + DW'(d_beat);
      if (s_en) wait_cnt = s_rdy ? 0 : wait_cnt + 1;
      m_ready = rnd_mem ? 1'($urandom_range(0, 1)) : (wait_cnt >= stall);
      m_rdata = $urandom;
      n++;
    end
    if (i_act || d_act) timed_out = 1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 0;
    i_req = 1; d_req = 1; i_we = 0; d_we = 1;
    i_addr = 32'h2000_0010; d_addr = 32'h3000_0020;
    i_wdata = 32'h1111_1111; d_wdata = 32'h2222_2222;
    m_ready = 1; m_rdata = 32'hDEAD_BEEF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({m_en, m_we, m_addr, m_wdata, i_ready, d_ready, i_offset, d_offset, rdata} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got en=%b we=%b addr=%h wdata=%h ir=%b dr=%b io=%0d do=%0d rdata=%h, required all 0",
               m_en, m_we, m_addr, m_wdata, i_ready, d_ready, i_offset, d_offset, rdata);
    end
    checks++;
    if (dbg_state !== ARB_IDLE || dbg_count !== '0) begin
      errors++;
      $display("FAIL reset_state: got state=%0d count=%0d, required 0/0", dbg_state, dbg_count);
    end
    apply_reset();
  endtask

  task automatic test_single_read();
    apply_reset(); clear_obs(); set_mem(0, 0);
    start_req(REQ_D, 0, 32'h1000_0004, 4);
    expect_burst(REQ_D, 0, 32'h1000_0004, d_base, 4);
    run(50);
    checks++;
    if (timed_out) begin errors++; $display("FAIL single_read timeout: burst did not finish in 50 cycles"); end
    checks++;
    if (first_en != 1) begin errors++; $display("FAIL single_read grant_latency: got %0d required 1", first_en); end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL single_read beat_count: got %0d required %0d", obs_q.size(), exp_q.size());
    end
    for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
      checks++;
      if (obs_q[k] !== exp_q[k]) begin
        errors++; $display("FAIL single_read beat %0d: got %h required %h", k, obs_q[k], exp_q[k]);
      end
    end
    checks++;
    if (bad_ready != 0 || rd_diff != 0) begin
      errors++; $display("FAIL single_read ready/rdata: got bad_ready=%0d rd_diff=%0d required 0/0", bad_ready, rd_diff);
    end
    @(negedge clk);
    checks++;
    if (dbg_state !== ARB_IDLE || dbg_count !== '0 || m_en !== 1'b0) begin
      errors++; $display("FAIL single_read end_idle: got state=%0d count=%0d m_en=%b required 0/0/0", dbg_state, dbg_count, m_en);
    end
  endtask

  task automatic test_round_robin();
    apply_reset(); set_mem(0, 0);
    for (int r = 0; r < 2; r++) begin
      clear_obs();
      start_req(REQ_I, 0, $urandom, 4);
      start_req(REQ_D, 0, $urandom, 4);
      expect_burst(REQ_I, 0, i_addr, i_base, 4);
      expect_burst(REQ_D, 0, d_addr, d_base, 4);
      run(60);
      checks++;
      if (timed_out) begin errors++; $display("FAIL round_robin %0d timeout", r); end
      checks++;
      if (obs_q.size() != exp_q.size()) begin
        errors++; $display("FAIL round_robin %0d beat_count: got %0d required %0d", r, obs_q.size(), exp_q.size());
      end
      for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
        checks++;
        if (obs_q[k] !== exp_q[k]) begin
          errors++; $display("FAIL round_robin %0d beat %0d: got %h required %h", r, k, obs_q[k], exp_q[k]);
        end
      end
      checks++;
      if (gaps.size() != 1 || gaps[0] != 1) begin
        errors++; $display("FAIL round_robin %0d idle_gap: got %0d gaps (first %0d) required one gap of 1",
                           r, gaps.size(), (gaps.size() > 0) ? gaps[0] : -1);
      end
    end
  endtask

  task automatic test_write_stall();
    int writes;
    apply_reset(); clear_obs(); set_mem(3, 0);
    start_req(REQ_D, 1, 32'h0400_0A3C, 4);
    expect_burst(REQ_D, 1, d_addr, d_base, 4);
    run(1);
    start_req(REQ_I, 0, 32'h0800_0100, 4);
    expect_burst(REQ_I, 0, i_addr, i_base, 4);
    run(200);
    checks++;
    if (timed_out) begin errors++; $display("FAIL write_stall timeout"); end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL write_stall beat_count: got %0d required %0d", obs_q.size(), exp_q.size());
    end
    for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
      checks++;
      if (obs_q[k] !== exp_q[k]) begin
        errors++; $display("FAIL write_stall beat %0d: got %h required %h", k, obs_q[k], exp_q[k]);
      end
    end
    writes = 0;
    foreach (obs_q[k]) if (obs_q[k][EW-2]) writes++;
    checks++;
    if (writes != 4) begin errors++; $display("FAIL write_stall write_count: got %0d required 4", writes); end
    checks++;
    if (unstable != 0 || bad_ready != 0) begin
      errors++; $display("FAIL write_stall stall_hold: got unstable=%0d bad_ready=%0d required 0/0", unstable, bad_ready);
    end
  endtask

  task automatic test_abort();
    apply_reset(); clear_obs(); set_mem(0, 0);
    start_req(REQ_D, 0, 32'h5000_0008, 2);
    // The beat completing in the drop cycle is still delivered.
    expect_burst(REQ_D, 0, d_addr, d_base, 3);
    run(1);
    start_req(REQ_I, 0, 32'h6000_0040, 4);
    expect_burst(REQ_I, 0, i_addr, i_base, 4);
    run(60);
    checks++;
    if (timed_out) begin errors++; $display("FAIL abort timeout"); end
    checks++;
    if (gaps.size() != 1 || gaps[0] != 1) begin
      errors++; $display("FAIL abort idle_gap: got %0d gaps (first %0d) required one gap of 1",
                         gaps.size(), (gaps.size() > 0) ? gaps[0] : -1);
    end
    start_req(REQ_D, 0, 32'h5000_0008, 4);
    expect_burst(REQ_D, 0, d_addr, d_base, 4);
    run(60);
    checks++;
    if (timed_out) begin errors++; $display("FAIL abort restart_timeout"); end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL abort beat_count: got %0d required %0d", obs_q.size(), exp_q.size());
    end
    for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
      checks++;
      if (obs_q[k] !== exp_q[k]) begin
        errors++; $display("FAIL abort beat %0d: got %h required %h", k, obs_q[k], exp_q[k]);
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    apply_reset(); clear_obs(); set_mem(0, 0);
    start_req(REQ_I, 0, 32'h7000_00C0, 4);
    run(3);
    checks++;
    if (i_offset !== 2'd2 || m_en !== 1'b1) begin
      errors++; $display("FAIL reset_mid setup: got offset=%0d m_en=%b required 2/1", i_offset, m_en);
    end
    #2 reset = 0;
    #1;
    checks++;
    if (m_en !== 1'b0 || i_ready !== 1'b0 || m_addr !== '0) begin
      errors++; $display("FAIL reset_mid async_drop: got m_en=%b i_ready=%b m_addr=%h required 0/0/0", m_en, i_ready, m_addr);
    end
    checks++;
    if (dbg_state !== ARB_IDLE || dbg_count !== '0) begin
      errors++; $display("FAIL reset_mid state: got state=%0d count=%0d required 0/0", dbg_state, dbg_count);
    end
    @(posedge clk);
    @(negedge clk) reset = 1;
    @(posedge clk); #1;
    clear_obs(); set_mem(0, 0);
    start_req(REQ_I, 0, 32'h7000_00C0, 4);
    expect_burst(REQ_I, 0, i_addr, i_base, 4);
    run(40);
    checks++;
    if (timed_out) begin errors++; $display("FAIL reset_mid restart_timeout"); end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL reset_mid beat_count: got %0d required %0d", obs_q.size(), exp_q.size());
    end
    for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
      checks++;
      if (obs_q[k] !== exp_q[k]) begin
        errors++; $display("FAIL reset_mid beat %0d: got %h required %h", k, obs_q[k], exp_q[k]);
      end
    end
  endtask

  task automatic test_idle_ready();
    int pulses, ens;
    apply_reset();
    pulses = 0; ens = 0;
    m_ready = 1;
    repeat (10) begin
      m_rdata = $urandom;
      @(negedge clk);
      pulses += int'(i_ready) + int'(d_ready);
      ens += int'(m_en);
      @(posedge clk); #1;
    end
    checks++;
    if (pulses != 0 || ens != 0) begin
      errors++; $display("FAIL idle_ready pulses: got ready=%0d m_en=%0d required 0/0", pulses, ens);
    end
    checks++;
    if (dbg_count !== '0 || dbg_state !== ARB_IDLE) begin
      errors++; $display("FAIL idle_ready state: got state=%0d count=%0d required 0/0", dbg_state, dbg_count);
    end
  endtask

  task automatic test_random();
    bit model_last, first, we;
    int pat;
    apply_reset();
    model_last = REQ_D;
    for (int r = 0; r < 24; r++) begin
      clear_obs(); set_mem(0, 1);
      pat = $urandom_range(1, 3);
      we = 1'($urandom_range(0, 1));
      if (pat[0]) start_req(REQ_I, 0, $urandom, 4);
      if (pat[1]) start_req(REQ_D, we, $urandom, 4);
      if (pat == 3) begin
        first = (model_last == REQ_D) ? REQ_I : REQ_D;
        model_last = ~first;
      end else begin
        first = (pat == 1) ? REQ_I : REQ_D;
        model_last = first;
      end
      if (pat != 2) begin
        if (first == REQ_I) expect_burst(REQ_I, 0, i_addr, i_base, 4);
      end
      if (pat != 1) expect_burst(REQ_D, we, d_addr, d_base, 4);
      if (pat == 3 && first == REQ_D) expect_burst(REQ_I, 0, i_addr, i_base, 4);
      run(300);
      checks++;
      if (timed_out) begin errors++; $display("FAIL random %0d timeout", r); end
      checks++;
      if (obs_q.size() != exp_q.size()) begin
        errors++; $display("FAIL random %0d beat_count: got %0d required %0d", r, obs_q.size(), exp_q.size());
      end
      for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
        checks++;
        if (obs_q[k] !== exp_q[k]) begin
          errors++; $display("FAIL random %0d beat %0d: got %h required %h", r, k, obs_q[k], exp_q[k]);
        end
      end
      if (pat == 3) begin
        checks++;
        if (gaps.size() != 1 || gaps[0] != 1) begin
          errors++; $display("FAIL random %0d idle_gap: got %0d gaps (first %0d) required one gap of 1",
                             r, gaps.size(), (gaps.size() > 0) ? gaps[0] : -1);
        end
      end
      checks++;
      if (bad_ready != 0 || unstable != 0 || rd_diff != 0) begin
        errors++; $display("FAIL random %0d protocol: got bad_ready=%0d unstable=%0d rd_diff=%0d required 0/0/0",
                           r, bad_ready, unstable, rd_diff);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_write_stall();
    test_abort();
    test_reset_mid_burst();
    test_idle_ready();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
